// File: rtl/calendar_counter_if.sv
// Purpose: bundles the slow-clock request, run/load controls and date/time outputs of calendar_counter.
// Ports: master drives clk_trl/run/ld/ld_* and observes the counters; slave is the counter side.
// Signals: year 7b, month 4b, day 5b, hour 5b, min 6b, sec 6b, plus tick/carry_day/ld_err pulses.
interface calendar_counter_if;
  logic       clk_trl;
  logic       run;
  logic       ld;
  logic [6:0] ld_year;
  logic [3:0] ld_month;
  logic [4:0] ld_day;
  logic [4:0] ld_hour;
  logic [5:0] ld_min;
  logic [5:0] ld_sec;
  logic [6:0] year;
  logic [3:0] month;
  logic [4:0] day;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       tick;
  logic       carry_day;
  logic       ld_err;

  modport master (
    output clk_trl, run, ld, ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec,
    input  year, month, day, hour, min, sec, tick, carry_day, ld_err
  );

  modport slave (
    input  clk_trl, run, ld, ld_year, ld_month, ld_day, ld_hour, ld_min, ld_sec,
    output year, month, day, hour, min, sec, tick, carry_day, ld_err
  );
endinterface

// File: rtl/calendar_counter.sv
// Purpose: time-of-day and date counter (2000..2099) advanced by rising edges of the async slow clock clk_trl.
// Latency: clk_trl rise sampled at E0 -> counters and tick update at E0+SYNC_STAGES; loads visible next cycle.
// Backpressure: none; requests arriving with run=0 or alongside ld are dropped.
// Ports: clk, rst (sync, active-high), cal (calendar_counter_if.slave). Parameter SYNC_STAGES (2..4).
// Option: CAL_LEAP_EN defined enables Feb 29 in leap years (year[1:0]==0) for advance and load checks.
module calendar_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  calendar_counter_if.slave        cal
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   req;

  logic [6:0] year_q,  year_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q,   day_d;
  logic [4:0] hour_q,  hour_d;
  logic [5:0] min_q,   min_d;
  logic [5:0] sec_q,   sec_d;
  logic       tick_q,  tick_d;
  logic       carry_q, carry_d;
  logic       err_q,   err_d;

  logic       leap_cur, leap_ld;
  logic [4:0] dim_cur, dim_ld;
  logic       ld_ok;

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

`ifdef CAL_LEAP_EN
  // year[1:0]==0 is the exact Gregorian rule inside 2000..2099.
  assign leap_cur = (year_q[1:0] == 2'b00);
  assign leap_ld  = (cal.ld_year[1:0] == 2'b00);
`else
  assign leap_cur = 1'b0;
  assign leap_ld  = 1'b0;
`endif

  assign dim_cur = days_in_month(month_q, leap_cur);
  assign dim_ld  = days_in_month(cal.ld_month, leap_ld);

  // One request per rising edge: last sync stage high while the history flop still holds the old level.
  assign req = sync_q[SYNC_STAGES-1] & ~hist_q;

  assign ld_ok = (cal.ld_year <= 7'd99) &&
                 (cal.ld_month >= 4'd1) && (cal.ld_month <= 4'd12) &&
                 (cal.ld_day >= 5'd1) && (cal.ld_day <= dim_ld) &&
                 (cal.ld_hour <= 5'd23) && (cal.ld_min <= 6'd59) && (cal.ld_sec <= 6'd59);

  always_comb begin
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (cal.ld) begin
      // Load takes priority; a coincident request is simply lost.
      if (ld_ok) begin
        year_d  = cal.ld_year;
        month_d = cal.ld_month;
        day_d   = cal.ld_day;
        hour_d  = cal.ld_hour;
        min_d   = cal.ld_min;
        sec_d   = cal.ld_sec;
      end else begin
        err_d = 1'b1;
      end
    end else if (req && cal.run) begin
      tick_d = 1'b1;
      sec_d  = sec_q + 6'd1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        min_d = min_q + 6'd1;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = hour_q + 5'd1;
          if (hour_q == 5'd23) begin
            hour_d  = 5'd0;
            carry_d = 1'b1;
            day_d   = day_q + 5'd1;
            if (day_q == dim_cur) begin
              day_d   = 5'd1;
              month_d = month_q + 4'd1;
              if (month_q == 4'd12) begin
                month_d = 4'd1;
                year_d  = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      year_q  <= 7'd0;
      month_q <= 4'd1;
      day_q   <= 5'd1;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Synchroniser and history keep tracking regardless of run/ld.
      sync_q  <= {sync_q[SYNC_STAGES-2:0], cal.clk_trl};
      hist_q  <= sync_q[SYNC_STAGES-1];
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign cal.year      = year_q;
  assign cal.month     = month_q;
  assign cal.day       = day_q;
  assign cal.hour      = hour_q;
  assign cal.min       = min_q;
  assign cal.sec       = sec_q;
  assign cal.tick      = tick_q;
  assign cal.carry_day = carry_q;
  assign cal.ld_err    = err_q;

endmodule
